// File: rtl/selector_pkg.sv
// Shared constants for the 8:1 selector datapath and its receiving deserializer.
package selector_pkg;

    localparam int unsigned SEL_WIDTH = 8;
    localparam int unsigned SEL_IDX_W = 3;

    // Frame FSM encoding, shared with the serializer side of the link.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/decoder8.sv
// 3-to-8 one-hot decoder with enable; the structural inverse of the selector tree.
module decoder8
    import selector_pkg::*;
(
    input  logic                 en,
    input  logic [SEL_IDX_W-1:0] idx,
    output logic [0:SEL_WIDTH-1] hot
);

    always_comb begin
        hot = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            hot[i] = en && (idx == SEL_IDX_W'(i));
        end
    end

endmodule

// File: rtl/deselector8.sv
// Serial-to-parallel receiver: strobed bits land in a[s]; completed word shown with a valid pulse.
module deselector8
    import selector_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 en,
    input  logic                 x,
    output logic [0:SEL_WIDTH-1] a,
    output logic                 valid,
    output logic [SEL_IDX_W-1:0] s,
    output logic                 busy,
    output logic                 err
);

    logic [0:0]           state_q, state_d;
    logic [0:SEL_WIDTH-1] shadow_q, shadow_d, shadow_base, we;
    logic [0:SEL_WIDTH-1] a_d;
    logic [SEL_IDX_W-1:0] s_d;
    logic                 valid_d, err_d;
    logic                 collecting, last_idx;

    assign collecting = (state_q == ST_COLLECT);
    assign last_idx   = (s == SEL_IDX_W'(SEL_WIDTH - 1));
    assign busy       = collecting;

    // A start always restarts at index 0, so the decoder sees 0 in that cycle.
    decoder8 u_decoder8 (
        .en  (en && (start || collecting)),
        .idx (start ? '0 : s),
        .hot (we)
    );

    always_comb begin
        shadow_base = start ? '0 : shadow_q;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            shadow_d[i] = we[i] ? x : shadow_base[i];
        end

        state_d = state_q;
        s_d     = s;
        a_d     = a;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (start) begin
            state_d = ST_COLLECT;
            err_d   = collecting;
            s_d     = en ? SEL_IDX_W'(1) : '0;
        end else if (collecting && en) begin
            if (last_idx) begin
                a_d     = shadow_d;
                valid_d = 1'b1;
                state_d = ST_IDLE;
                s_d     = '0;
            end else begin
                s_d = s + SEL_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            a        <= '0;
            s        <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            a        <= a_d;
            s        <= s_d;
            valid    <= valid_d;
            err      <= err_d;
        end
    end

endmodule

// File: doc/deselector8.md
# deselector8

Serial-to-parallel receiver for the 8:1 selector path: the far end of a link whose transmitter walks a 3-bit select from 0 to 7 and sends one bit per strobe. The block demultiplexes each strobed bit into position `a[s]` of an 8-bit word, then presents the completed word with a one-cycle valid pulse. It sits at the receiving end of the selector datapath, and its bit-index ordering matches the selector's select encoding (bit i travels when s == i).

## Interface
- Parameters: none. Width is fixed at 8 and the index width at 3, both taken from the shared package.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new frame; clears the bit index to 0.
- `en` in 1: bit strobe; `x` is sampled on a rising edge where `en` = 1.
- `x` in 1: serial data bit.
- `a` out [0:7]: last completed word; `a[i]` holds the bit received at index i.
- `valid` out 1: one-cycle pulse when `a` is updated.
- `s` out [2:0]: index the next strobed bit will be written to.
- `busy` out 1: 1 while a frame is in progress (state COLLECT).
- `err` out 1: one-cycle pulse when `start` aborts an unfinished frame.

## Operation
- **Reset values:** `a` = 8'h00, `valid` = 0, `s` = 0, `busy` = 0, `err` = 0, state = IDLE, internal shadow word = 0.
- **States:** IDLE and COLLECT.
- **IDLE:**
  - `en` without `start` is ignored. `s` stays 0.
  - `start` = 1: go to COLLECT with `s` = 0.
  - `start` and `en` in the same cycle: `x` is captured into shadow[0], and the block enters COLLECT with `s` = 1.
- **COLLECT, `en` = 1, `start` = 0:**
  - shadow[s] <= x, then s <= s+1.
  - If s == 7: a <= shadow with bit 7 = x, and `valid` pulses on the next cycle. State returns to IDLE and `s` wraps to 0.
- **COLLECT, `en` = 0:** hold. There is no timeout, and gaps between strobes are unlimited.
- **COLLECT, `start` = 1 (abort):**
  - `err` pulses and the partial shadow word is discarded. `a` is unchanged and no `valid` is issued.
  - The frame restarts at `s` = 0. If `en` is also 1, `x` goes to shadow[0] and `s` becomes 1.
  - This applies even at s == 7: the restart wins, the 8th bit belongs to the new frame, and no `valid` is issued.
- **Output word:** `a` holds the last completed word until the next completion. It is never partially updated.
- **Shadow word:** cleared to 0 on every `start`.
- **Reset mid-frame:** everything returns to reset values immediately; the partial frame is lost with no `err`.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `valid` and the new `a` appear together, one cycle after the edge that samples the 8th bit.
- **Minimum frame:** `start`+`en` on cycle 0 followed by `en` on cycles 1–7 gives `valid` high during cycle 8.
- **Back-to-back frames:** a new `start`+`en` may be applied in the same cycle `valid` is high.
- `err` is high for exactly one cycle, in the cycle after the aborting `start`.
- `busy` is 1 from the cycle after `start` until the cycle after the 8th bit (the same cycle `valid` rises; `busy` is 0 then).

## Structure
- **Shared package `selector_pkg`:**
  - `SEL_WIDTH` = 8 and `SEL_IDX_W` = 3.
  - The state encoding (IDLE = 0, COLLECT = 1), shared with any future serializer FSM.
- **Sub-module `decoder8`:**
  - Combinational 3-to-8 one-hot decoder with an enable input.
  - Drives the per-bit write enables of the shadow register (output bit i high when enable = 1 and s == i).
  - It is the structural inverse of the selector tree and is reusable by other demux blocks.

## Test plan
- **Basic frame:** reset, then `start`+`en` with `x` = 1,0,1,1,0,0,1,0 on 8 consecutive strobes. Expect `a` = 10110010 (a[0] = 1), `valid` high for 1 cycle at cycle 8, and `s` back to 0.
- **Gapped strobes:** same data with `en` low for 3 cycles between each bit. Expect the same `a`, and `valid` only after the 8th strobe.
- **Abort:** start a frame, send 5 bits, then `start`+`en` with a new 8-bit word 0xFF (all 1s). Expect `err` pulses once, `a` = 11111111, and exactly one `valid`.
- **Back-to-back:** frame 0x0F then frame 0xF0, with the second `start` in the same cycle as the first `valid`. Expect two `valid` pulses 8 cycles apart, and `a` = 00001111 then 11110000.
- **Reset mid-frame:** assert `rst` asynchronously after 4 bits. Expect `a` = 0, `s` = 0, `busy` = 0 immediately. Then 4 more `en` with no `start` produce no `valid`.
- **IDLE strobes:** `en` toggling with no `start` for 20 cycles. Expect `s` = 0, `busy` = 0, `valid` = 0, `a` unchanged.
